rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8_if.sv | 12 +
 rtl/rr_arbiter_8.sv | 83 ++++++++
 tb/tb_rr_arbiter_8.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle for the 8-way round-robin arbiter.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  modport master (output req, done, input gnt, gnt_idx, busy, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, busy, timeout);
endinterface

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with single-owner grant, done release and
// forced release after MAX_HOLD cycles.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_8_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] hold, hold_nxt;
  logic       to_q, to_nxt;
  logic [7:0] rot;
  logic [2:0] win;

  // Rotate req so bit 0 is the ptr position; lowest set bit wins.
  always_comb begin
    rot = 8'({bus.req, bus.req} >> ptr);
    win = ptr;
    for (int i = 7; i >= 0; i--)
      if (rot[i]) win = ptr + 3'(i);
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    hold_nxt  = hold;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = GRANT;
          idx_nxt   = win;
          ptr_nxt   = win + 3'd1;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        // done wins over the forced-release condition, so no timeout then
        if (bus.done) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (hold == HOLD_LAST) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          to_nxt    = 1'b1;
        end else begin
          hold_nxt = hold + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      hold  <= '0;
      to_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx   <= idx_nxt;
      hold  <= hold_nxt;
      to_q  <= to_nxt;
    end
  end

  // Grant is decoded from registered state so reset clears it immediately.
  assign bus.gnt     = (state == GRANT) ? (8'b1 << idx) : 8'h00;
  assign bus.gnt_idx = idx;
  assign bus.busy    = (state == GRANT);
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed + randomized bench for rr_arbiter_8 against a behavioural
// owner/pointer model.
module tb_rr_arbiter_8;
  localparam int MAX_HOLD = 16;

  logic clk;
  logic rst_n;
  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: owner = -1 when nobody holds the grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    if (m_owner < 0) begin
      m_to = 1'b0;
      if (r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr + k) % 8;
          if (r[c] && m_owner < 0) m_owner = c;
        end
        m_ptr  = (m_owner + 1) % 8;
        m_held = 1;
      end
    end else if (d) begin
      m_owner = -1;
      m_to    = 1'b0;
    end else if (m_held == MAX_HOLD) begin
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_held++;
      m_to = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    logic [7:0] eg;
    logic [2:0] ei;
    eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    ei = (m_owner < 0) ? 3'd0 : m_owner[2:0];
    checks++;
    assert (bus.gnt === eg) else begin
      errors++;
      $error("FAIL %s gnt got %h want %h", tag, bus.gnt, eg);
    end
    checks++;
    assert (bus.gnt_idx === ei) else begin
      errors++;
      $error("FAIL %s gnt_idx got %0d want %0d", tag, bus.gnt_idx, ei);
    end
    checks++;
    assert (bus.busy === (m_owner >= 0)) else begin
      errors++;
      $error("FAIL %s busy got %b want %b", tag, bus.busy, m_owner >= 0);
    end
    checks++;
    assert (bus.timeout === m_to) else begin
      errors++;
      $error("FAIL %s timeout got %b want %b", tag, bus.timeout, m_to);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d, input string tag);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
    model_edge(r, d);
    check(tag);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check(tag);
    bus.req  = 8'h00;
    bus.done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full request vector, one-cycle ownership each: visits 0..7 then 0.
    for (int g = 0; g < 9; g++) begin
      step(8'hFF, 1'b0, "rr_ff_grant");
      step(8'hFF, 1'b1, "rr_ff_gap");
    end

    // Idle with no requests.
    step(8'h00, 1'b0, "idle");
    step(8'h00, 1'b1, "idle_done");

    // Pointer wrap: 4, 7, then 4 again.
    mid_reset("reset2");
    for (int g = 0; g < 3; g++) begin
      step(8'h90, 1'b0, "wrap_grant");
      step(8'h90, 1'b1, "wrap_rel");
    end

    // Forced release: 16 granted cycles then one timeout pulse.
    step(8'h04, 1'b0, "to_grant");
    for (int c = 0; c < MAX_HOLD - 1; c++) step(8'h00, 1'b0, "to_hold");
    step(8'h00, 1'b0, "to_drop");
    checks++;
    assert (bus.timeout === 1'b1 && bus.gnt === 8'h00) else begin
      errors++;
      $error("FAIL to_pulse timeout/gnt got %b/%h want 1/00", bus.timeout, bus.gnt);
    end
    step(8'h00, 1'b0, "to_after");

    // done coincides with the last hold cycle: normal release.
    step(8'h04, 1'b0, "tie_grant");
    for (int c = 0; c < MAX_HOLD - 1; c++) step(8'h04, 1'b0, "tie_hold");
    step(8'h00, 1'b1, "tie_rel");
    checks++;
    assert (bus.timeout === 1'b0 && bus.gnt === 8'h00) else begin
      errors++;
      $error("FAIL tie_rel timeout/gnt got %b/%h want 0/00", bus.timeout, bus.gnt);
    end

    // Owner drops req, another rises: grant held until done.
    step(8'h08, 1'b0, "hold_grant");
    step(8'h20, 1'b0, "hold_keep");
    step(8'h20, 1'b0, "hold_keep");
    step(8'h20, 1'b1, "hold_rel");
    step(8'h20, 1'b0, "hold_next");
    checks++;
    assert (bus.gnt === 8'h20) else begin
      errors++;
      $error("FAIL hold_next gnt got %h want 20", bus.gnt);
    end

    // Reset mid-grant, then restart from pointer 0.
    step(8'h40, 1'b0, "mr_grant");
    mid_reset("mr_reset");
    step(8'h01, 1'b0, "mr_regrant");

    // Randomized traffic.
    step(8'h00, 1'b1, "rnd_pre");
    for (int n = 0; n < 600; n++) begin
      logic [7:0] r;
      logic       d;
      r = 8'($urandom);
      if (n % 3 == 0) r = r & 8'($urandom);
      d = ($urandom_range(0, 9) < 2);
      step(r, d, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
